bcd_counter4: RTL and testbench
===============================

# bcd_counter4

Four-digit synchronous BCD up/down counter that generates the digit values consumed by the BCD-to-seven-segment decoder stage. Each 4-bit digit output feeds one decoder instance directly, and the counter guarantees every digit stays in the range 0–9. The block sits between the board-level control inputs (enable, direction, load switches) and the display decode/drive path. An internal prescaler sets the count rate, so the same block serves both simulation (fast) and board use (human-visible).

## Interface
- `TICK_DIV`, default 1: clock cycles per count step, legal range ≥1; 1 means one step per enabled cycle.
- `clk` input 1: the single clock; every register updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `en` input 1: count enable; while low, the prescaler holds its value and the count holds.
- `up` input 1: direction; 1 counts up, 0 counts down. Sampled only on step cycles.
- `load` input 1: synchronous parallel load of `load_val`.
- `load_val` input 16: four BCD digits, [15:12] most significant, [3:0] least significant.
- `bcd` output 16: current count, same digit packing as `load_val`. Registered.
- `carry` output 1: one-cycle pulse on wrap-around (9999→0000 counting up, 0000→9999 counting down). Registered.

## Operation
- Priority per cycle: `reset` > `load` > step > hold.
- `reset`: `bcd`=16'h0000, `carry`=0, prescaler=0.
- `load`:
  - Each digit of `load_val` greater than 9 is clamped to 9; all other digits load as given.
  - Prescaler returns to 0; `carry`=0.
  - `en` and `up` are ignored that cycle.
- Prescaler: counts 0..TICK_DIV-1 while `en`=1, wraps to 0, and a step occurs on the cycle it equals TICK_DIV-1. With TICK_DIV=1, a step occurs on every cycle with `en`=1.
- Step, counting up:
  - The least significant digit increments.
  - A digit at 9 goes to 0 and passes a carry to the next digit.
  - A ripple out of the most significant digit sets `carry`=1 for that one cycle.
- Step, counting down:
  - The least significant digit decrements.
  - A digit at 0 goes to 9 and passes a borrow to the next digit.
  - A borrow out of the most significant digit sets `carry`=1.
- `carry`=0 on every cycle without a wrap.
- Digits never hold 10–15, regardless of stimulus.
- Direction change mid-count takes effect on the next step. There is no extra latency and no lost step.

## Timing
- All outputs update one clock after the qualifying edge. Latency from input to `bcd` is 1 cycle for load, step and reset alike.
- `reset` asserted mid-count: `bcd`=0 and `carry`=0 on the next edge, even if a step or load is pending.
- `load` and a step in the same cycle: the load wins, and the step is discarded. The next step arrives TICK_DIV enabled cycles later.
- `en` deasserted: the prescaler freezes, it does not clear. Resuming `en` continues the partial period.
- `carry` rises in the same cycle `bcd` shows the wrapped value and lasts exactly 1 cycle. Two consecutive wraps are impossible for TICK_DIV≥1 with 4 digits.

## Structure
- Shared package/include holds:
  - `BCD_MAX` = 4'd9
  - `BCD_DIGITS` = 4
  - digit width 4
- The natural sub-module is `bcd_digit`, a single registered digit:
  - Inputs: `clk`, `reset`, `ld`, `ld_val[3:0]`, `step_in` (carry/borrow in), `up`.
  - Outputs: `q[3:0]`, `step_out`.
  - Instantiate it 4× as a ripple chain.
- The prescaler, priority logic and `carry` register live in the top level.

## Test plan
- Reset, then `en`=1, `up`=1, TICK_DIV=1 for 12 cycles → `bcd` = 0001, 0002 … 0009, 0010, 0011, 0012; `carry` stays 0.
- Load 16'h9998, `up`=1, `en`=1 → next steps give 9999, then 0000 with `carry`=1 for exactly 1 cycle, then 0001 with `carry`=0.
- Load 16'h0001, `up`=0 → steps give 0000, then 9999 with `carry`=1, then 9998.
- Load 16'hFA3C → `bcd`=16'h9939 (digits >9 clamped). Then count up 1 step → 9940.
- TICK_DIV=3, count from 0000 with `en` toggled low for 2 cycles mid-period → one step per 3 enabled cycles; the frozen cycles add no steps.
- Apply `reset` and `load` together during a wrap step → `bcd`=0000, `carry`=0. Separately, `load` 16'h0500 with a simultaneous step → `bcd`=0500 and no carry.

Source files
------------

// File: rtl/bcd_counter4_pkg.sv
// Shared constants and helpers for the four-digit BCD counter and its digit cells.
package bcd_counter4_pkg;

    localparam int DIGIT_W = 4;
    localparam int BCD_DIGITS = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Out-of-range load digits saturate so a digit can never leave 0..9.
    function automatic digit_t clampDigit(input digit_t value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage

// File: rtl/bcd_counter4_if.sv
// Control and display bus between the board controls and the BCD counter.
interface bcd_counter4_if;
    import bcd_counter4_pkg::*;

    logic                          en;
    logic                          up;
    logic                          load;
    logic [BCD_DIGITS*DIGIT_W-1:0] load_val;
    logic [BCD_DIGITS*DIGIT_W-1:0] bcd;
    logic                          carry;

    modport master (
        output en,
        output up,
        output load,
        output load_val,
        input  bcd,
        input  carry
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_val,
        output bcd,
        output carry
    );

endinterface

// File: rtl/bcd_counter4_digit.sv
// One registered BCD digit with ripple carry/borrow, chained four times by the top level.
module bcd_digit
    import bcd_counter4_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   ld,
    input  digit_t ld_val,
    input  logic   step_in,
    input  logic   up,
    output digit_t q,
    output logic   step_out
);

    digit_t digit_q;
    digit_t digit_d;

    // The ripple passes on only when this digit is about to wrap in the current direction.
    assign step_out = step_in && (up ? (digit_q == BCD_MAX) : (digit_q == '0));
    assign q        = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (ld) begin
            digit_d = clampDigit(ld_val);
        end else if (step_in) begin
            if (up) begin
                digit_d = (digit_q >= BCD_MAX) ? '0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == '0 || digit_q > BCD_MAX) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with prescaler, parallel load and wrap pulse.
module bcd_counter4
    import bcd_counter4_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input logic                clk,
    input logic                reset,
    bcd_counter4_if.slave      bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]         prescQ;
    logic [PW-1:0]         prescD;
    logic                  carryQ;
    logic                  carryD;
    logic                  stepNow;
    logic [BCD_DIGITS:0]   ripple;
    digit_t                digitQ [BCD_DIGITS];

    // A load in the same cycle swallows the step so the loaded value is not disturbed.
    assign stepNow   = bus.en && !bus.load && (prescQ == PRESC_LAST);
    assign ripple[0] = stepNow;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
        bcd_digit uDigit (
            .clk      (clk),
            .reset    (reset),
            .ld       (bus.load),
            .ld_val   (bus.load_val[i*DIGIT_W +: DIGIT_W]),
            .step_in  (ripple[i]),
            .up       (bus.up),
            .q        (digitQ[i]),
            .step_out (ripple[i+1])
        );
        assign bus.bcd[i*DIGIT_W +: DIGIT_W] = digitQ[i];
    end

    always_comb begin
        prescD = prescQ;
        carryD = 1'b0;
        if (bus.load) begin
            prescD = '0;
        end else if (bus.en) begin
            prescD = (prescQ == PRESC_LAST) ? '0 : prescQ + 1'b1;
            carryD = ripple[BCD_DIGITS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescQ <= '0;
            carryQ <= 1'b0;
        end else begin
            prescQ <= prescD;
            carryQ <= carryD;
        end
    end

    assign bus.carry = carryQ;

endmodule

// File: tb/tb_bcd_counter4.sv
// Directed self-checking bench: one counter at TICK_DIV=1 and one at TICK_DIV=3.
module tb_bcd_counter4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bcd_counter4_if busA ();
    bcd_counter4_if busB ();

    bcd_counter4 #(.TICK_DIV(1)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA.slave)
    );

    bcd_counter4 #(.TICK_DIV(3)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, so they are stable long before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic isB, input logic en, input logic up,
                                 input logic load, input logic [15:0] loadVal);
        if (isB) begin
            busB.en = en; busB.up = up; busB.load = load; busB.load_val = loadVal;
        end else begin
            busA.en = en; busA.up = up; busA.load = load; busA.load_val = loadVal;
        end
    endtask

    task automatic checkOutput(input string tag, input logic isB,
                               input logic [15:0] expBcd, input logic expCarry);
        logic [15:0] gotBcd;
        logic        gotCarry;
        gotBcd   = isB ? busB.bcd : busA.bcd;
        gotCarry = isB ? busB.carry : busA.carry;
        checks++;
        assert (gotBcd === expBcd) else begin
            errors++;
            $error("FAIL %s bcd got %h expected %h", tag, gotBcd, expBcd);
        end
        checks++;
        assert (gotCarry === expCarry) else begin
            errors++;
            $error("FAIL %s carry got %b expected %b", tag, gotCarry, expCarry);
        end
    endtask

    logic [15:0] upSeq [12];

    initial begin
        checks = 0;
        errors = 0;
        upSeq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                  16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'h0012};

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        tick();
        checkOutput("resetA", 1'b0, 16'h0000, 1'b0);
        checkOutput("resetB", 1'b1, 16'h0000, 1'b0);
        reset = 1'b0;

        // Plain up count across a decade boundary.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput($sformatf("up%0d", i + 1), 1'b0, upSeq[i], 1'b0);
        end

        // Up wrap 9999 -> 0000 with a one-cycle carry.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h9998);
        tick();
        checkOutput("load9998", 1'b0, 16'h9998, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(); checkOutput("up9999", 1'b0, 16'h9999, 1'b0);
        tick(); checkOutput("upWrap", 1'b0, 16'h0000, 1'b1);
        tick(); checkOutput("upAfterWrap", 1'b0, 16'h0001, 1'b0);

        // Down wrap 0000 -> 9999.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001);
        tick(); checkOutput("load0001", 1'b0, 16'h0001, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(); checkOutput("dn0000", 1'b0, 16'h0000, 1'b0);
        tick(); checkOutput("dnWrap", 1'b0, 16'h9999, 1'b1);
        tick(); checkOutput("dn9998", 1'b0, 16'h9998, 1'b0);

        // Clamped load, then one up step.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hFA3C);
        tick(); checkOutput("loadClamp", 1'b0, 16'h9939, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(); checkOutput("clampStep", 1'b0, 16'h9940, 1'b0);

        // Reset beats a load and a wrapping step in the same cycle.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h9999);
        tick(); checkOutput("load9999", 1'b0, 16'h9999, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
        reset = 1'b1;
        tick(); checkOutput("resetWins", 1'b0, 16'h0000, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

        // Load beats a simultaneous step, then direction change and hold.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0500);
        tick(); checkOutput("loadWinsA", 1'b0, 16'h0500, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(); checkOutput("after0500", 1'b0, 16'h0501, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(); checkOutput("dirChange", 1'b0, 16'h0500, 1'b0);
        tick(); checkOutput("dirChange2", 1'b0, 16'h0499, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick(); checkOutput("holdA", 1'b0, 16'h0499, 1'b0);

        // Prescaled counter: one step per three enabled cycles, frozen while en is low.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(); checkOutput("divP1", 1'b1, 16'h0000, 1'b0);
        tick(); checkOutput("divP2", 1'b1, 16'h0000, 1'b0);
        tick(); checkOutput("divStep1", 1'b1, 16'h0001, 1'b0);
        tick(); checkOutput("divP1b", 1'b1, 16'h0001, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick(); checkOutput("divFrz1", 1'b1, 16'h0001, 1'b0);
        tick(); checkOutput("divFrz2", 1'b1, 16'h0001, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(); checkOutput("divResume", 1'b1, 16'h0001, 1'b0);
        tick(); checkOutput("divStep2", 1'b1, 16'h0002, 1'b0);

        // Load on the step cycle restarts the period from zero.
        tick(); checkOutput("divQ1", 1'b1, 16'h0002, 1'b0);
        tick(); checkOutput("divQ2", 1'b1, 16'h0002, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0500);
        tick(); checkOutput("loadWinsB", 1'b1, 16'h0500, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(); checkOutput("divL1", 1'b1, 16'h0500, 1'b0);
        tick(); checkOutput("divL2", 1'b1, 16'h0500, 1'b0);
        tick(); checkOutput("divL3", 1'b1, 16'h0501, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
